mem_port_arbiter: RTL and testbench

Single-memory port arbiter between the CPU's instruction-fetch and data-access paths and the shared von Neumann memory. It accepts one read request from the fetch side and one read/write request from the data side, serialises them onto the single readM/writeM/address/data memory bus, waits a fixed memory latency, and returns a one-cycle acknowledge plus read data to the winning requester. Data side has priority, with alternation so the fetch side cannot starve.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_latency_counter.sv | 22 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_RESP   = 2'd2
  } mem_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Data side wins unless it won the previous grant and fetch is also waiting.
  function automatic owner_e pick_owner(logic i_pend, logic d_pend, owner_e last);
    if (d_pend && i_pend) return (last == OWNER_D) ? OWNER_I : OWNER_D;
    else if (d_pend)      return OWNER_D;
    else                  return OWNER_I;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the memory access window.
module mem_latency_counter import mem_port_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has precedence; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset)                     cnt_q <= '0;
    else if (load_i)               cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch reads and data reads/writes onto one memory bus.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e           state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_q, last_d;
  owner_e               grant;
  logic                 is_wr_q, is_wr_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 readM_q, readM_d;
  logic                 writeM_q, writeM_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 busy_q, busy_d;
  logic                 d_pend;
  logic                 cnt_load, cnt_dec, cnt_zero;

  mem_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state and registered-output decode for the access FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    readM_d   = 1'b0;
    writeM_d  = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    d_pend    = d_read | d_write;
    grant     = pick_owner(i_req, d_pend, last_q);

    unique case (state_q)
      MEM_IDLE: begin
        if (d_pend || i_req) begin
          state_d  = MEM_ACCESS;
          owner_d  = grant;
          last_d   = grant;
          // A simultaneous read+write on the data side is a write.
          is_wr_d  = (grant == OWNER_D) && d_write;
          addr_d   = (grant == OWNER_D) ? d_addr : i_addr;
          wdata_d  = d_wdata;
          cnt_load = 1'b1;
          readM_d  = !is_wr_d;
          writeM_d = is_wr_d;
        end
      end
      MEM_ACCESS: begin
        if (cnt_zero) begin
          state_d = MEM_RESP;
          if (!is_wr_q) begin
            if (owner_q == OWNER_D) d_rdata_d = data;
            else                    i_rdata_d = data;
          end
          if (owner_q == OWNER_D) d_ack_d = 1'b1;
          else                    i_ack_d = 1'b1;
        end else begin
          cnt_dec  = 1'b1;
          readM_d  = !is_wr_q;
          writeM_d = is_wr_q;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase

    busy_d = (state_d != MEM_IDLE);
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MEM_IDLE;
      owner_q   <= OWNER_I;
      last_q    <= OWNER_I;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      readM_q   <= 1'b0;
      writeM_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      readM_q   <= readM_d;
      writeM_q  <= writeM_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign readM   = readM_q;
  assign writeM  = writeM_q;
  assign address = addr_q;
  assign busy    = busy_q;

  // The bus is ours only while the write strobe register is set.
  assign data = writeM_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a queue-free order model.
module tb_mem_port_arbiter;

  localparam int W   = 16;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset, mem_init;
  logic         i_req, d_read, d_write;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  wire  [W-1:0] i_rdata, d_rdata, address, data_bus;
  wire          i_ack, d_ack, readM, writeM, busy;

  logic [W-1:0] phys_mem [0:255];
  logic [W-1:0] ref_mem  [0:255];
  int           checks = 0, errors = 0;
  int           m_last;           // 0 = fetch served last, 1 = data served last
  logic [W-1:0] m_ird, m_drd;     // model of the held read-data registers

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(int a);
    if (a == 16) return 16'hBEEF;
    return {a[7:0], ~a[7:0]};
  endfunction

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .readM(readM), .writeM(writeM), .address(address), .data(data_bus), .busy(busy));

  // Behavioural memory: drives the bus on reads, commits on write strobes.
  assign data_bus = (readM && !writeM) ? phys_mem[address[7:0]] : 'z;
  always @(posedge clk) begin
    if (mem_init) for (int a = 0; a < 256; a++) phys_mem[a] <= init_val(a);
    else if (writeM) phys_mem[address[7:0]] <= data_bus;
  end

  // Extra builds at the latency extremes share the request inputs.
  wire [W-1:0] a1, a15, r1i, r15i, r1d, r15d, bus1, bus15;
  wire         rm1, wm1, ia1, da1, b1, rm15, wm15, ia15, da15, b15;
  assign bus1  = (rm1 && !wm1)   ? (a1 ^ 16'hA5A5)  : 'z;
  assign bus15 = (rm15 && !wm15) ? (a15 ^ 16'hA5A5) : 'z;

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(r1i), .i_ack(ia1),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(r1d),
    .d_ack(da1), .readM(rm1), .writeM(wm1), .address(a1), .data(bus1), .busy(b1));

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(r15i), .i_ack(ia15),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(r15d),
    .d_ack(da15), .readM(rm15), .writeM(wm15), .address(a15), .data(bus15), .busy(b15));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    m_last = 0; m_ird = '0; m_drd = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    step(); step();
    checks++; if (readM !== 1'b0)  begin errors++; $display("FAIL reset_readM got %b exp 0", readM); end
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got %b exp 0", writeM); end
    checks++; if (address !== '0)  begin errors++; $display("FAIL reset_address got %h exp 0", address); end
    checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b exp 00", i_ack, d_ack); end
    checks++; if (i_rdata !== '0 || d_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", i_rdata, d_rdata); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 0;
    m_last = 0; m_ird = '0; m_drd = '0;
  endtask

  task automatic test_fetch();
    logic e;
    i_req = 1; i_addr = 16'h0010;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      e = (k <= LAT);
      checks++; if (readM !== e) begin errors++; $display("FAIL fetch_readM k=%0d got %b exp %b", k, readM, e); end
      if (readM === 1'b1) begin
        checks++; if (address !== 16'h0010) begin errors++; $display("FAIL fetch_addr got %h exp 0010", address); end
      end
      e = (k == LAT + 1);
      checks++; if (i_ack !== e || d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack k=%0d got i%b d%b exp i%b d0", k, i_ack, d_ack, e); end
      if (k == LAT + 1) begin
        m_ird = ref_mem[8'h10];
        checks++; if (i_rdata !== m_ird) begin errors++; $display("FAIL fetch_rdata got %h exp %h", i_rdata, m_ird); end
        i_req = 0; m_last = 0;
      end
    end
  endtask

  task automatic test_write();
    logic e;
    d_write = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      e = (k <= LAT);
      checks++; if (writeM !== e || readM !== 1'b0) begin errors++; $display("FAIL write_strobes k=%0d got w%b r%b exp w%b r0", k, writeM, readM, e); end
      if (writeM === 1'b1) begin
        checks++; if (data_bus !== 16'h1234) begin errors++; $display("FAIL write_data got %h exp 1234", data_bus); end
      end
      e = (k == LAT + 1);
      checks++; if (d_ack !== e || i_ack !== 1'b0) begin errors++; $display("FAIL write_ack k=%0d got d%b i%b exp d%b i0", k, d_ack, i_ack, e); end
      checks++; if (d_rdata !== m_drd) begin errors++; $display("FAIL write_rdata_kept got %h exp %h", d_rdata, m_drd); end
      if (k == LAT + 1) begin d_write = 0; ref_mem[8'h20] = 16'h1234; m_last = 1; end
    end
    d_read = 1;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      if (k == LAT + 1) begin
        m_drd = ref_mem[8'h20];
        checks++; if (d_ack !== 1'b1 || d_rdata !== m_drd) begin errors++; $display("FAIL readback got ack %b data %h exp ack 1 data %h", d_ack, d_rdata, m_drd); end
        d_read = 0;
      end
    end
  endtask

  task automatic test_alternate();
    int served, last_k, own, exp_own;
    logic [7:0] ia, da;
    do_reset();
    ia = 8'($urandom_range(0, 255)); da = 8'($urandom_range(0, 255));
    i_req = 1; i_addr = {8'h00, ia}; d_read = 1; d_addr = {8'h00, da};
    served = 0; last_k = 0;
    for (int k = 1; k <= 4 * (LAT + 2) + 6 && served < 4; k++) begin
      step();
      checks++; if (i_ack && d_ack) begin errors++; $display("FAIL alt_both_acks k=%0d got 11 exp one", k); end
      if (i_ack || d_ack) begin
        own = d_ack ? 1 : 0;
        exp_own = (m_last == 1) ? 0 : 1;
        checks++; if (own != exp_own) begin errors++; $display("FAIL alt_owner n=%0d got %0d exp %0d", served, own, exp_own); end
        checks++; if (k - last_k != ((served == 0) ? LAT + 1 : LAT + 2)) begin errors++; $display("FAIL alt_spacing n=%0d got %0d", served, k - last_k); end
        if (own == 1) begin
          m_drd = ref_mem[da];
          checks++; if (d_rdata !== m_drd) begin errors++; $display("FAIL alt_drdata got %h exp %h", d_rdata, m_drd); end
        end else begin
          m_ird = ref_mem[ia];
          checks++; if (i_rdata !== m_ird) begin errors++; $display("FAIL alt_irdata got %h exp %h", i_rdata, m_ird); end
        end
        m_last = own; last_k = k; served++;
      end
    end
    checks++; if (served != 4) begin errors++; $display("FAIL alt_timeout got %0d acks exp 4", served); end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_rw_both();
    logic e;
    logic [W-1:0] wd;
    wd = 16'($urandom);
    d_read = 1; d_write = 1; d_addr = 16'h0030; d_wdata = wd;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      e = (k <= LAT);
      checks++; if (readM !== 1'b0 || writeM !== e) begin errors++; $display("FAIL rw_strobes k=%0d got r%b w%b exp r0 w%b", k, readM, writeM, e); end
      if (writeM === 1'b1) begin
        checks++; if (data_bus !== wd) begin errors++; $display("FAIL rw_data got %h exp %h", data_bus, wd); end
      end
      if (k == LAT + 1) begin
        checks++; if (d_ack !== 1'b1 || d_rdata !== m_drd) begin errors++; $display("FAIL rw_ack got %b data %h exp 1 data %h", d_ack, d_rdata, m_drd); end
        d_read = 0; d_write = 0; ref_mem[8'h30] = wd; m_last = 1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] da;
    int got;
    i_req = 1; i_addr = 16'h0077;
    step();
    checks++; if (readM !== 1'b1) begin errors++; $display("FAIL mid_readM_before got %b exp 1", readM); end
    reset = 1; i_req = 0;
    step();
    checks++; if (readM !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abort got r%b b%b exp 00", readM, busy); end
    reset = 0; m_last = 0; m_ird = '0; m_drd = '0;
    got = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      step();
      if (i_ack || d_ack || i_rdata !== '0) got++;
    end
    checks++; if (got != 0) begin errors++; $display("FAIL mid_no_ack got %0d bad cycles exp 0", got); end
    da = 8'($urandom_range(0, 255));
    d_read = 1; d_addr = {8'h00, da};
    got = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      if (d_ack) begin
        got = k;
        m_drd = ref_mem[da];
        checks++; if (d_rdata !== m_drd) begin errors++; $display("FAIL mid_recover_data got %h exp %h", d_rdata, m_drd); end
        d_read = 0; m_last = 1;
      end
    end
    checks++; if (got != LAT + 1) begin errors++; $display("FAIL mid_recover_ack got cycle %0d exp %0d", got, LAT + 1); end
  endtask

  task automatic test_latency();
    int km, k1, k15;
    do_reset();
    i_req = 1; i_addr = 16'h0055;
    km = 0; k1 = 0; k15 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (i_ack && km == 0) km = k;
      if (ia1 && k1 == 0) begin
        k1 = k;
        checks++; if (r1i !== (16'h0055 ^ 16'hA5A5)) begin errors++; $display("FAIL lat1_data got %h exp %h", r1i, 16'h0055 ^ 16'hA5A5); end
      end
      if (ia15 && k15 == 0) begin
        k15 = k;
        checks++; if (r15i !== (16'h0055 ^ 16'hA5A5)) begin errors++; $display("FAIL lat15_data got %h exp %h", r15i, 16'h0055 ^ 16'hA5A5); end
      end
    end
    checks++; if (km != LAT + 1) begin errors++; $display("FAIL lat_main got %0d exp %0d", km, LAT + 1); end
    checks++; if (k1 != 2)       begin errors++; $display("FAIL lat1 got %0d exp 2", k1); end
    checks++; if (k15 != 16)     begin errors++; $display("FAIL lat15 got %0d exp 16", k15); end
    do_reset();
  endtask

  task automatic test_random();
    int pat, ia_at, da_at, left;
    logic use_i, use_d, d_wr, first_d;
    logic [7:0] ia, da;
    logic [W-1:0] wd;
    for (int n = 0; n < 30; n++) begin
      pat = $urandom_range(0, 4);
      use_i = (pat == 0) || (pat >= 3);
      use_d = (pat != 0);
      d_wr  = (pat == 2) || (pat == 4);
      ia = 8'($urandom_range(64, 79)); da = 8'($urandom_range(64, 79)); wd = 16'($urandom);
      first_d = (use_i && use_d) ? (m_last == 0) : use_d;
      // Apply effects in service order so a write ahead of a read is visible.
      if (first_d) begin
        if (d_wr) ref_mem[da] = wd; else m_drd = ref_mem[da];
        if (use_i) m_ird = ref_mem[ia];
      end else begin
        m_ird = ref_mem[ia];
        if (use_d) begin if (d_wr) ref_mem[da] = wd; else m_drd = ref_mem[da]; end
      end
      ia_at = !use_i ? 0 : (use_d && first_d) ? 2 * LAT + 3 : LAT + 1;
      da_at = !use_d ? 0 : (use_i && !first_d) ? 2 * LAT + 3 : LAT + 1;
      if (use_i && use_d) m_last = first_d ? 0 : 1;
      else                m_last = use_d ? 1 : 0;
      i_req = use_i; i_addr = {8'h00, ia};
      d_read = use_d && !d_wr; d_write = use_d && d_wr; d_addr = {8'h00, da}; d_wdata = wd;
      left = int'(use_i) + int'(use_d);
      for (int k = 1; k <= 2 * LAT + 5 && left > 0; k++) begin
        step();
        checks++; if (i_ack && d_ack) begin errors++; $display("FAIL rnd_both_acks n=%0d k=%0d", n, k); end
        if (writeM === 1'b1) begin
          checks++; if (data_bus !== wd || readM !== 1'b0) begin errors++; $display("FAIL rnd_wbus n=%0d got %h r%b exp %h r0", n, data_bus, readM, wd); end
        end
        if (i_ack) begin
          checks++; if (k != ia_at || i_rdata !== m_ird) begin errors++; $display("FAIL rnd_iack n=%0d got k%0d %h exp k%0d %h", n, k, i_rdata, ia_at, m_ird); end
          i_req = 0; left--;
        end
        if (d_ack) begin
          checks++; if (k != da_at || d_rdata !== m_drd) begin errors++; $display("FAIL rnd_dack n=%0d got k%0d %h exp k%0d %h", n, k, d_rdata, da_at, m_drd); end
          d_read = 0; d_write = 0; left--;
        end
      end
      checks++; if (left != 0) begin errors++; $display("FAIL rnd_timeout n=%0d got %0d pending exp 0", n, left); end
      clear_inputs();
      step();
    end
  endtask

  initial begin
    reset = 1; mem_init = 1;
    clear_inputs();
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
    m_last = 0; m_ird = '0; m_drd = '0;
    step();
    mem_init = 0;
    test_reset();
    test_fetch();
    test_write();
    test_alternate();
    test_rw_both();
    test_reset_mid();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
